// File: rtl/tick_scheduler_if.sv
// ----------------------------------------------------------------------------
// tick_scheduler_if
// Control and timebase bundle for the game-speed tick scheduler.
//   start, pause, crash : game control inputs to the scheduler
//   tick                : one-clk pulse per period
//   m                   : square wave toggling on every tick
//   level               : current speed level
//   cur_period          : period in force for the current interval
//   running, game_over  : state indications (RUN / OVER)
// master = the side driving the game controls, slave = the scheduler.
// ----------------------------------------------------------------------------
interface tick_scheduler_if;
    logic        start;
    logic        pause;
    logic        crash;
    logic        tick;
    logic        m;
    logic [3:0]  level;
    logic [31:0] cur_period;
    logic        running;
    logic        game_over;

    modport master (
        output start, pause, crash,
        input  tick, m, level, cur_period, running, game_over
    );

    modport slave (
        input  start, pause, crash,
        output tick, m, level, cur_period, running, game_over
    );
endinterface

// File: rtl/tick_scheduler.sv
// ----------------------------------------------------------------------------
// tick_scheduler
// Game-speed timebase: a programmable divider whose period shrinks by STEP
// every TICKS_PER_LEVEL ticks (floored at MIN_PERIOD, level saturating at
// MAX_LEVEL), wrapped in an IDLE / RUN / PAUSED / OVER game state machine.
// Ports:
//   clk  : system clock
//   rst  : synchronous active-high reset, overrides everything
//   bus  : tick_scheduler_if.slave (start/pause/crash in; tick, m, level,
//          cur_period, running, game_over out -- all outputs registered)
// ----------------------------------------------------------------------------
module tick_scheduler #(
    parameter logic [31:0] BASE_PERIOD     = 32'd15000000,
    parameter logic [31:0] STEP            = 32'd1000000,
    parameter logic [31:0] MIN_PERIOD      = 32'd3000000,
    parameter logic [7:0]  TICKS_PER_LEVEL = 8'd64,
    parameter logic [3:0]  MAX_LEVEL       = 4'd12
) (
    input  logic              clk,
    input  logic              rst,
    tick_scheduler_if.slave   bus
);

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_RUN    = 2'd1,
        ST_PAUSED = 2'd2,
        ST_OVER   = 2'd3
    } state_t;

    state_t      state_r;
    logic [31:0] cnt_r;
    logic [7:0]  tick_cnt_r;
    logic [3:0]  level_r;
    logic [31:0] cur_period_r;
    logic        tick_r;
    logic        m_r;
    logic        running_r;
    logic        game_over_r;

    logic        terminal_s;
    logic        level_end_s;
    logic [3:0]  level_next_s;
    logic [31:0] period_next_s;

    // Period for a given level. The product is formed at 36 bits so that a
    // level*STEP larger than BASE_PERIOD clamps to the floor instead of
    // wrapping around to a huge period.
    function automatic logic [31:0] period_f(input logic [3:0] lvl);
        logic [35:0] prod;
        logic [31:0] diff;
        prod = 36'(lvl) * 36'(STEP);
        diff = 32'd0;
        if (prod > {4'd0, BASE_PERIOD}) begin
            period_f = MIN_PERIOD;
        end else begin
            diff = BASE_PERIOD - prod[31:0];
            if (diff < MIN_PERIOD) begin
                period_f = MIN_PERIOD;
            end else begin
                period_f = diff;
            end
        end
    endfunction

    // Terminal-count and level-advance decode, plus the period the next level
    // will use so it can be loaded on the same edge the level changes.
    always_comb begin
        terminal_s    = (cnt_r == (cur_period_r - 32'd1));
        level_end_s   = (tick_cnt_r == (TICKS_PER_LEVEL - 8'd1));
        level_next_s  = level_r;
        if (level_r < MAX_LEVEL) begin
            level_next_s = level_r + 4'd1;
        end else begin
            level_next_s = level_r;
        end
        period_next_s = period_f(level_next_s);
    end

    // Game state machine with the divider, level sequencer and registered outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r      <= ST_IDLE;
            cnt_r        <= 32'd0;
            tick_cnt_r   <= 8'd0;
            level_r      <= 4'd0;
            cur_period_r <= BASE_PERIOD;
            tick_r       <= 1'b0;
            m_r          <= 1'b0;
            running_r    <= 1'b0;
            game_over_r  <= 1'b0;
        end else begin
            // tick only ever rises for the single cycle after a terminal count
            tick_r <= 1'b0;
            case (state_r)
                ST_IDLE: begin
                    cnt_r <= 32'd0;
                    if (bus.start) begin
                        state_r      <= ST_RUN;
                        tick_cnt_r   <= 8'd0;
                        level_r      <= 4'd0;
                        cur_period_r <= BASE_PERIOD;
                        running_r    <= 1'b1;
                        game_over_r  <= 1'b0;
                    end else begin
                        running_r    <= 1'b0;
                        game_over_r  <= 1'b0;
                    end
                end
                ST_RUN: begin
                    // crash beats pause beats terminal count; leaving RUN
                    // freezes cnt and suppresses any tick on that edge
                    if (bus.crash) begin
                        state_r     <= ST_OVER;
                        running_r   <= 1'b0;
                        game_over_r <= 1'b1;
                    end else if (bus.pause) begin
                        state_r     <= ST_PAUSED;
                        running_r   <= 1'b0;
                    end else if (terminal_s) begin
                        cnt_r  <= 32'd0;
                        tick_r <= 1'b1;
                        m_r    <= ~m_r;
                        if (level_end_s) begin
                            tick_cnt_r   <= 8'd0;
                            level_r      <= level_next_s;
                            cur_period_r <= period_next_s;
                        end else begin
                            tick_cnt_r   <= tick_cnt_r + 8'd1;
                        end
                    end else begin
                        cnt_r <= cnt_r + 32'd1;
                    end
                end
                ST_PAUSED: begin
                    if (bus.crash) begin
                        state_r     <= ST_OVER;
                        game_over_r <= 1'b1;
                    end else if (!bus.pause) begin
                        state_r   <= ST_RUN;
                        running_r <= 1'b1;
                    end else begin
                        state_r <= ST_PAUSED;
                    end
                end
                ST_OVER: begin
                    // final level stays visible until the next start
                    if (bus.start) begin
                        state_r      <= ST_RUN;
                        cnt_r        <= 32'd0;
                        tick_cnt_r   <= 8'd0;
                        level_r      <= 4'd0;
                        cur_period_r <= BASE_PERIOD;
                        running_r    <= 1'b1;
                        game_over_r  <= 1'b0;
                    end else begin
                        state_r <= ST_OVER;
                    end
                end
                default: begin
                    state_r     <= ST_IDLE;
                    running_r   <= 1'b0;
                    game_over_r <= 1'b0;
                end
            endcase
        end
    end

    assign bus.tick       = tick_r;
    assign bus.m          = m_r;
    assign bus.level      = level_r;
    assign bus.cur_period = cur_period_r;
    assign bus.running    = running_r;
    assign bus.game_over  = game_over_r;

endmodule

// File: tb/tb_tick_scheduler.sv
// ----------------------------------------------------------------------------
// tb_tick_scheduler
// Directed bench for tick_scheduler. dut1 uses the small test timing
// (20/4/8/4/4) and is checked every cycle against a behavioural model that
// derives level from the number of ticks in the run and m from the parity of
// ticks since reset. dut2 (10/6/3/1/4) exercises the clamp without wrap.
// ----------------------------------------------------------------------------
module tb_tick_scheduler;

    localparam int T_BASE = 20;
    localparam int T_STEP = 4;
    localparam int T_MIN  = 8;
    localparam int T_TPL  = 4;
    localparam int T_MAX  = 4;

    localparam int M_IDLE   = 0;
    localparam int M_RUN    = 1;
    localparam int M_PAUSED = 2;
    localparam int M_OVER   = 3;

    logic clk;
    logic rst1;
    logic rst2;

    int total;
    int bad;

    tick_scheduler_if if1();
    tick_scheduler_if if2();

    tick_scheduler #(
        .BASE_PERIOD    (32'd20),
        .STEP           (32'd4),
        .MIN_PERIOD     (32'd8),
        .TICKS_PER_LEVEL(8'd4),
        .MAX_LEVEL      (4'd4)
    ) dut1 (
        .clk (clk),
        .rst (rst1),
        .bus (if1)
    );

    tick_scheduler #(
        .BASE_PERIOD    (32'd10),
        .STEP           (32'd6),
        .MIN_PERIOD     (32'd3),
        .TICKS_PER_LEVEL(8'd1),
        .MAX_LEVEL      (4'd4)
    ) dut2 (
        .clk (clk),
        .rst (rst2),
        .bus (if2)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- behavioural model of dut1 ----------------
    function automatic int per(input int lvl);
        int prod;
        prod = lvl * T_STEP;
        if (prod > T_BASE) return T_MIN;
        if (T_BASE - prod < T_MIN) return T_MIN;
        return T_BASE - prod;
    endfunction

    function automatic int lvl_of(input int run_ticks);
        int l;
        l = run_ticks / T_TPL;
        return (l > T_MAX) ? T_MAX : l;
    endfunction

    int mst;
    int elapsed;       // RUN cycles spent in the current interval
    int run_ticks;     // ticks since the run began
    int all_ticks;     // ticks since reset (m parity)
    int exp_tick;
    bit model_valid;

    initial begin
        mst = M_IDLE; elapsed = 0; run_ticks = 0; all_ticks = 0;
        exp_tick = 0; model_valid = 1'b0;
    end

    always @(posedge clk) begin
        exp_tick = 0;
        if (rst1) begin
            mst = M_IDLE; elapsed = 0; run_ticks = 0; all_ticks = 0;
            model_valid = 1'b1;
        end else begin
            case (mst)
                M_IDLE: if (if1.start) begin mst = M_RUN; elapsed = 0; run_ticks = 0; end
                M_RUN: begin
                    if (if1.crash) mst = M_OVER;
                    else if (if1.pause) mst = M_PAUSED;
                    else begin
                        elapsed++;
                        if (elapsed == per(lvl_of(run_ticks))) begin
                            elapsed = 0; exp_tick = 1; run_ticks++; all_ticks++;
                        end
                    end
                end
                M_PAUSED: begin
                    if (if1.crash) mst = M_OVER;
                    else if (!if1.pause) mst = M_RUN;
                end
                M_OVER: if (if1.start) begin mst = M_RUN; elapsed = 0; run_ticks = 0; end
                default: mst = M_IDLE;
            endcase
        end
    end

    // compare every cycle on the falling edge
    always @(negedge clk) begin
        if (model_valid) begin
            chk("cyc_tick",    32'(if1.tick),       32'(exp_tick));
            chk("cyc_m",       32'(if1.m),          32'(all_ticks % 2));
            chk("cyc_level",   32'(if1.level),      32'(lvl_of(run_ticks)));
            chk("cyc_period",  if1.cur_period,      32'(per(lvl_of(run_ticks))));
            chk("cyc_running", 32'(if1.running),    32'(mst == M_RUN));
            chk("cyc_over",    32'(if1.game_over),  32'(mst == M_OVER));
        end
    end

    // ---------------- directed stimulus ----------------
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // steps until the selected DUT shows tick; bounded
    task automatic wait_tick(input int which, output int n);
        n = 0;
        do begin
            step();
            n++;
        end while (((which == 1) ? if1.tick : if2.tick) !== 1'b1 && n < 300);
    endtask

    int n;
    int sp;
    logic m_before;

    initial begin
        rst1 = 1'b1; rst2 = 1'b1;
        if1.start = 1'b0; if1.pause = 1'b0; if1.crash = 1'b0;
        if2.start = 1'b0; if2.pause = 1'b0; if2.crash = 1'b0;
        total = 0; bad = 0;
        step(); step();
        rst1 = 1'b0;

        // reset values
        chk("rst_tick",    32'(if1.tick), 32'd0);
        chk("rst_m",       32'(if1.m), 32'd0);
        chk("rst_level",   32'(if1.level), 32'd0);
        chk("rst_period",  if1.cur_period, 32'd20);
        chk("rst_running", 32'(if1.running), 32'd0);
        chk("rst_over",    32'(if1.game_over), 32'd0);

        // start and run through all level boundaries
        if1.start = 1'b1;
        step();
        if1.start = 1'b0;
        chk("start_running", 32'(if1.running), 32'd1);
        for (int k = 1; k <= 40; k++) begin
            wait_tick(1, n);
            sp = (k <= 4) ? 20 : (k <= 8) ? 16 : (k <= 12) ? 12 : 8;
            chk("spacing", 32'(n), 32'(sp));
            chk("m_toggle", 32'(if1.m), 32'(k % 2));
        end
        chk("sat_level",  32'(if1.level), 32'd4);
        chk("sat_period", if1.cur_period, 32'd8);

        // pause coinciding with terminal count (period 8, cnt 7)
        repeat (7) step();
        if1.pause = 1'b1;
        for (int i = 0; i < 50; i++) begin
            step();
            chk("pause_tick", 32'(if1.tick), 32'd0);
        end
        chk("pause_m", 32'(if1.m), 32'd0);
        if1.pause = 1'b0;
        step();
        wait_tick(1, n);
        chk("pause_tc_resume", 32'(n), 32'd1);

        // crash from level 4, then restart
        if1.crash = 1'b1;
        step();
        if1.crash = 1'b0;
        chk("crash_over",  32'(if1.game_over), 32'd1);
        chk("crash_level", 32'(if1.level), 32'd4);
        if1.start = 1'b1;
        step();
        if1.start = 1'b0;
        chk("restart_level",  32'(if1.level), 32'd0);
        chk("restart_period", if1.cur_period, 32'd20);

        // pause at cnt 7, level 0 -> 13 cycles to the tick after resume
        repeat (7) step();
        if1.pause = 1'b1;
        repeat (50) step();
        if1.pause = 1'b0;
        step();
        wait_tick(1, n);
        chk("pause7_resume", 32'(n), 32'd13);
        for (int k = 2; k <= 9; k++) begin
            wait_tick(1, n);
            sp = (k <= 4) ? 20 : (k <= 8) ? 16 : 12;
            chk("run2_spacing", 32'(n), 32'(sp));
        end

        // crash on terminal count at level 2 (period 12)
        chk("pre_crash_level", 32'(if1.level), 32'd2);
        m_before = if1.m;
        repeat (11) step();
        if1.crash = 1'b1;
        step();
        if1.crash = 1'b0;
        chk("crash_tc_tick",  32'(if1.tick), 32'd0);
        chk("crash_tc_over",  32'(if1.game_over), 32'd1);
        chk("crash_tc_level", 32'(if1.level), 32'd2);
        chk("crash_tc_m",     32'(if1.m), 32'(m_before));

        // start held high across the restart
        if1.start = 1'b1;
        step();
        chk("restart2_level",  32'(if1.level), 32'd0);
        chk("restart2_period", if1.cur_period, 32'd20);
        wait_tick(1, n);
        chk("restart2_first", 32'(n), 32'd20);
        if1.start = 1'b0;

        // reach level 3, then reset mid-run
        for (int k = 2; k <= 12; k++) wait_tick(1, n);
        chk("lvl3_level",  32'(if1.level), 32'd3);
        chk("lvl3_period", if1.cur_period, 32'd8);
        rst1 = 1'b1;
        step();
        rst1 = 1'b0;
        chk("mid_rst_tick",    32'(if1.tick), 32'd0);
        chk("mid_rst_m",       32'(if1.m), 32'd0);
        chk("mid_rst_level",   32'(if1.level), 32'd0);
        chk("mid_rst_period",  if1.cur_period, 32'd20);
        chk("mid_rst_running", 32'(if1.running), 32'd0);
        chk("mid_rst_over",    32'(if1.game_over), 32'd0);

        // pause/crash in IDLE do nothing
        if1.pause = 1'b1; if1.crash = 1'b1;
        repeat (5) step();
        chk("idle_running", 32'(if1.running), 32'd0);
        chk("idle_over",    32'(if1.game_over), 32'd0);
        if1.pause = 1'b0; if1.crash = 1'b0;
        if1.start = 1'b1;
        step();
        if1.start = 1'b0;
        wait_tick(1, n);
        chk("idle_restart_first", 32'(n), 32'd20);

        // dut2: 10/6/3, one tick per level -> 10, 4, 3, 3
        rst2 = 1'b0;
        chk("d2_rst_period", if2.cur_period, 32'd10);
        if2.start = 1'b1;
        step();
        if2.start = 1'b0;
        wait_tick(2, n);
        chk("d2_sp0", 32'(n), 32'd10);
        chk("d2_p1",  if2.cur_period, 32'd4);
        wait_tick(2, n);
        chk("d2_sp1", 32'(n), 32'd4);
        chk("d2_l2",  32'(if2.level), 32'd2);
        chk("d2_p2",  if2.cur_period, 32'd3);
        wait_tick(2, n);
        chk("d2_sp2", 32'(n), 32'd3);
        chk("d2_p3",  if2.cur_period, 32'd3);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/tick_scheduler.md
Name: tick_scheduler

Overview:
- Game-speed controller for the Fury on Wheels timebase: one programmable divider whose period it sequences across speed levels.
- Generates a one-cycle `tick` and a toggling `m` square wave that downstream motion/display logic consumes in place of a fixed-rate divider.
- Shortens the period by a fixed step every N ticks, clamped at a floor.
- Implements a start / pause / crash (game-over) state machine.

Parameters:
- BASE_PERIOD, 32'd15000000: tick interval in clk cycles at level 0.
- STEP, 32'd1000000: period reduction per level.
- MIN_PERIOD, 32'd3000000: period floor, must be >= 2.
- TICKS_PER_LEVEL, 8'd64: ticks spent at each level before advancing, must be >= 1.
- MAX_LEVEL, 4'd12: saturation level.

Ports:
- clk  input  1: system clock.
- rst  input  1: synchronous, active-high reset.
- start  input  1: level-sensitive, acted on in IDLE or OVER; begins a run.
- pause  input  1: held high to freeze the timebase while running.
- crash  input  1: single-cycle or held; ends the run.
- tick  output  1: one-clk pulse per period.
- m  output  1: toggles on every tick.
- level  output  4: current speed level.
- cur_period  output  32: period in force for the current interval.
- running  output  1: high in RUN only.
- game_over  output  1: high in OVER only.

Behaviour:
- Reset (rst sampled high at posedge, overrides everything) puts outputs in these values:
  - state = IDLE; tick = 0; m = 0; level = 0.
  - cur_period = BASE_PERIOD; running = 0; game_over = 0.
  - internal cnt = 0; tick_cnt = 0.
- Reset mid-run aborts with no tick emitted.
- Period rule: cur_period = BASE_PERIOD - level*STEP, in 32-bit unsigned arithmetic.
  - If level*STEP > BASE_PERIOD (no wrap), result is MIN_PERIOD.
  - If result < MIN_PERIOD, result is MIN_PERIOD.
  - cur_period is registered and updated on the same edge level changes.
- States IDLE, RUN, PAUSED, OVER. Event priority within a cycle: rst > crash > pause > terminal count.
- IDLE: cnt held 0.
  - start=1 -> RUN next cycle, with cnt = 0, tick_cnt = 0, level = 0.
  - crash and pause are ignored.
- RUN: cnt increments each cycle.
  - When cnt == cur_period-1 (terminal count), on that edge:
    - cnt <= 0; tick <= 1 for exactly one cycle; m <= ~m.
    - tick_cnt increments.
    - If tick_cnt == TICKS_PER_LEVEL-1: tick_cnt <= 0 and level <= min(level+1, MAX_LEVEL); the new cur_period governs the next interval.
  - Consecutive ticks are exactly cur_period cycles apart.
  - The first tick is asserted cur_period cycles after the first RUN cycle.
- Transitions out of RUN:
  - pause=1 -> PAUSED; cnt, tick_cnt, level, m frozen.
  - crash=1 -> OVER.
  - If either coincides with terminal count, no tick, m unchanged, cnt unchanged.
- PAUSED: all counters frozen; tick = 0.
  - crash=1 -> OVER.
  - Else pause=0 -> RUN, resuming from the frozen cnt.
  - If the frozen cnt == cur_period-1, the tick fires on the first RUN cycle.
- OVER: counters and level frozen (final level visible); tick = 0; m holds.
  - start=1 -> RUN with cnt, tick_cnt, level cleared and cur_period = BASE_PERIOD.
  - start held high has no effect once in RUN.
- Saturation: at MAX_LEVEL, tick_cnt keeps wrapping, and level and cur_period stay constant.
- tick is never high outside RUN, and never in the cycle RUN is left.

Test Plan (BASE_PERIOD=20, STEP=4, MIN_PERIOD=8, TICKS_PER_LEVEL=4, MAX_LEVEL=4):
- Reset, then start pulse -> running=1. First tick 20 cycles after RUN entry; ticks 1-4 spaced 20; m toggles each tick (0->1->0->1->0).
- Continuous run -> level 0->1->2->3->4 after ticks 4, 8, 12, 16. Spacings after those boundaries are 16, 12, 8, 8 (level 4 clamps at MIN_PERIOD 8). level stays 4 after 40 ticks.
- Pause asserted for 50 cycles at cnt=7 -> no tick during pause. Next tick 13 cycles after RUN resumes; pause coinciding with terminal count -> tick emitted on the first cycle after release.
- crash on the same cycle as terminal count at level 2 -> no tick, game_over=1, level=2, m unchanged. Start -> level=0, cur_period=20, first tick after 20 cycles.
- rst asserted mid-run at level 3 -> next cycle all outputs at reset values. start in IDLE restarts normally; pause/crash in IDLE have no effect.
- Parameter check with BASE_PERIOD=10, STEP=6, MIN_PERIOD=3 -> level 2 gives cur_period=3 (no unsigned wrap).
